decode_issue: RTL and testbench

//  RV32IM decode/issue stage. Registers one fetched instruction and emits the

---
 rtl/decode_issue.sv | 263 ++++++++++++++++++++++++++
 tb/tb_decode_issue.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/decode_issue.sv
// RV32IM decode/issue stage: registers one fetched instruction and presents the
// execute-stage bundle behind a single-entry valid/ready output register.

package decode_issue_pkg;

    typedef enum logic [5:0] {
        ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR, ALU_SRL, ALU_SRA,
        ALU_OR, ALU_AND,
        ALU_MUL, ALU_MULH, ALU_MULHSU, ALU_MULHU, ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU,
        ALU_LB, ALU_LH, ALU_LW, ALU_LBU, ALU_LHU,
        ALU_SB, ALU_SH, ALU_SW,
        ALU_LUI, ALU_JAL, ALU_JALR,
        ALU_BEQ, ALU_BNE, ALU_BLT, ALU_BGE, ALU_BLTU, ALU_BGEU
    } alu_e;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    typedef struct packed {
        logic [5:0]  alucode;
        logic [31:0] op1;
        logic [31:0] op2;
        logic [31:0] br_target;
        logic [31:0] pc;
        logic [4:0]  rd;
        logic        reg_we;
        logic        mem_we;
        logic        illegal;
    } bundle_t;

endpackage

module decode_issue
    import decode_issue_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_inst,
    input  logic [31:0] in_pc,
    output logic [4:0]  rs1_addr,
    output logic [4:0]  rs2_addr,
    input  logic [31:0] rs1_data,
    input  logic [31:0] rs2_data,
    input  logic        flush,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [5:0]  alucode,
    output logic [31:0] op1,
    output logic [31:0] op2,
    output logic [31:0] br_target,
    output logic [31:0] out_pc,
    output logic [4:0]  rd,
    output logic        reg_we,
    output logic        mem_we,
    output logic        illegal
);

    localparam bundle_t RESET_BUNDLE = '{
        alucode: ALU_ADD, op1: '0, op2: '0, br_target: '0, pc: RESET_PC,
        rd: '0, reg_we: 1'b0, mem_we: 1'b0, illegal: 1'b0
    };

    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [4:0]  rd_f;
    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
    logic [31:0] pc_plus4;

    assign opcode   = in_inst[6:0];
    assign rd_f     = in_inst[11:7];
    assign funct3   = in_inst[14:12];
    assign funct7   = in_inst[31:25];
    assign rs1_addr = in_inst[19:15];
    assign rs2_addr = in_inst[24:20];

    assign imm_i    = {{20{in_inst[31]}}, in_inst[31:20]};
    assign imm_s    = {{20{in_inst[31]}}, in_inst[31:25], in_inst[11:7]};
    assign imm_b    = {{19{in_inst[31]}}, in_inst[31], in_inst[7], in_inst[30:25], in_inst[11:8], 1'b0};
    assign imm_u    = {in_inst[31:12], 12'b0};
    assign imm_j    = {{11{in_inst[31]}}, in_inst[31], in_inst[19:12], in_inst[20], in_inst[30:21], 1'b0};
    assign pc_plus4 = in_pc + 32'd4;

    // Shared by OP and OP-IMM; alt selects SUB/SRA over ADD/SRL.
    function automatic logic [5:0] arith_op(input logic [2:0] f3, input logic alt);
        case (f3)
            3'd0:    arith_op = alt ? ALU_SUB : ALU_ADD;
            3'd1:    arith_op = ALU_SLL;
            3'd2:    arith_op = ALU_SLT;
            3'd3:    arith_op = ALU_SLTU;
            3'd4:    arith_op = ALU_XOR;
            3'd5:    arith_op = alt ? ALU_SRA : ALU_SRL;
            3'd6:    arith_op = ALU_OR;
            default: arith_op = ALU_AND;
        endcase
    endfunction

    bundle_t dec;
    logic    legal;
    logic    writes_rd;

    always_comb begin
        // NOTE: every signal driven here gets a default first so no path infers a latch.
        dec           = '0;
        dec.alucode   = ALU_ADD;
        dec.op1       = rs1_data;
        dec.op2       = rs2_data;
        dec.br_target = pc_plus4;
        dec.pc        = in_pc;
        dec.rd        = rd_f;
        legal         = 1'b1;
        writes_rd     = 1'b1;

        case (opcode)
            OPC_OP: begin
                case (funct7)
                    7'b0000000: dec.alucode = arith_op(funct3, 1'b0);
                    7'b0100000: begin
                        dec.alucode = arith_op(funct3, 1'b1);
                        legal       = (funct3 == 3'd0) || (funct3 == 3'd5);
                    end
                    7'b0000001: dec.alucode = 6'(int'(ALU_MUL) + int'(funct3));
                    default:    legal = 1'b0;
                endcase
            end
            OPC_OP_IMM: begin
                dec.op2 = imm_i;
                if (funct3 == 3'd1 || funct3 == 3'd5) begin
                    dec.op2     = {27'b0, in_inst[24:20]};
                    dec.alucode = arith_op(funct3, funct7[5]);
                    legal       = (funct7 == 7'b0000000) ||
                                  (funct3 == 3'd5 && funct7 == 7'b0100000);
                end else begin
                    dec.alucode = arith_op(funct3, 1'b0);
                end
            end
            OPC_LOAD: begin
                dec.op2 = imm_i;
                case (funct3)
                    3'd0:    dec.alucode = ALU_LB;
                    3'd1:    dec.alucode = ALU_LH;
                    3'd2:    dec.alucode = ALU_LW;
                    3'd4:    dec.alucode = ALU_LBU;
                    3'd5:    dec.alucode = ALU_LHU;
                    default: legal = 1'b0;
                endcase
            end
            OPC_STORE: begin
                dec.op2    = imm_s;
                dec.mem_we = 1'b1;
                writes_rd  = 1'b0;
                case (funct3)
                    3'd0:    dec.alucode = ALU_SB;
                    3'd1:    dec.alucode = ALU_SH;
                    3'd2:    dec.alucode = ALU_SW;
                    default: legal = 1'b0;
                endcase
            end
            OPC_LUI: begin
                dec.alucode = ALU_LUI;
                dec.op1     = '0;
                dec.op2     = imm_u;
            end
            OPC_AUIPC: begin
                dec.op1 = in_pc;
                dec.op2 = imm_u;
            end
            OPC_JAL: begin
                dec.alucode   = ALU_JAL;
                dec.op1       = '0;
                dec.op2       = in_pc;
                dec.br_target = in_pc + imm_j;
            end
            OPC_JALR: begin
                dec.alucode   = ALU_JALR;
                dec.op2       = in_pc;
                dec.br_target = (rs1_data + imm_i) & ~32'd1;
                legal         = (funct3 == 3'd0);
            end
            OPC_BRANCH: begin
                dec.br_target = in_pc + imm_b;
                writes_rd     = 1'b0;
                case (funct3)
                    3'd0:    dec.alucode = ALU_BEQ;
                    3'd1:    dec.alucode = ALU_BNE;
                    3'd4:    dec.alucode = ALU_BLT;
                    3'd5:    dec.alucode = ALU_BGE;
                    3'd6:    dec.alucode = ALU_BLTU;
                    3'd7:    dec.alucode = ALU_BGEU;
                    default: legal = 1'b0;
                endcase
            end
            default: legal = 1'b0;
        endcase

        if (!legal) begin
            dec.alucode = ALU_ADD;
            dec.op1     = '0;
            dec.op2     = '0;
            dec.rd      = '0;
            dec.mem_we  = 1'b0;
            dec.reg_we  = 1'b0;
            dec.illegal = 1'b1;
        end else begin
            dec.reg_we = writes_rd && (rd_f != 5'd0);
        end
    end

    logic    valid_q, valid_d;
    bundle_t bundle_q, bundle_d;
    logic    accept;

    assign in_ready = !valid_q || out_ready;
    assign accept   = in_valid && in_ready && !flush;

    // Flush wins over accept; a plain drain only clears valid, data is left in place.
    always_comb begin
        valid_d  = valid_q;
        bundle_d = bundle_q;
        if (flush) begin
            valid_d = 1'b0;
        end else if (accept) begin
            valid_d  = 1'b1;
            bundle_d = dec;
        end else if (out_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: state registers update with <= so every flop samples pre-edge values.
        if (!rst_n) begin
            valid_q  <= 1'b0;
            bundle_q <= RESET_BUNDLE;
        end else begin
            valid_q  <= valid_d;
            bundle_q <= bundle_d;
        end
    end

    assign out_valid = valid_q;
    assign alucode   = bundle_q.alucode;
    assign op1       = bundle_q.op1;
    assign op2       = bundle_q.op2;
    assign br_target = bundle_q.br_target;
    assign out_pc    = valid_q ? bundle_q.pc : RESET_PC;
    assign rd        = bundle_q.rd;
    assign reg_we    = bundle_q.reg_we;
    assign mem_we    = bundle_q.mem_we;
    assign illegal   = bundle_q.illegal;

endmodule

// File: tb/tb_decode_issue.sv
// Scoreboard bench for decode_issue: a table-driven RV32IM reference model feeds a
// queue of expected bundles that an independent negedge monitor checks.

module tb_decode_issue;
    import decode_issue_pkg::*;

    localparam logic [31:0] RST_PC = 32'h0000_1000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready, flush, out_valid, out_ready;
    logic [31:0] in_inst, in_pc, rs1_data, rs2_data;
    logic [4:0]  rs1_addr, rs2_addr, rd;
    logic [5:0]  alucode;
    logic [31:0] op1, op2, br_target, out_pc;
    logic        reg_we, mem_we, illegal;

    decode_issue #(.RESET_PC(RST_PC)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_inst(in_inst), .in_pc(in_pc),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rs1_data(rs1_data), .rs2_data(rs2_data),
        .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
        .alucode(alucode), .op1(op1), .op2(op2), .br_target(br_target), .out_pc(out_pc),
        .rd(rd), .reg_we(reg_we), .mem_we(mem_we), .illegal(illegal)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [5:0]  alu;
        logic [31:0] op1, op2, br, pc;
        logic [4:0]  rd;
        logic        reg_we, mem_we, ill;
        bit          op1_c, op2_c, br_c, rd_c;
    } exp_t;

    exp_t       sb[$];
    logic [5:0] enc_tbl [logic [16:0]];
    int         checks = 0;
    int         passed = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        else passed++;
    endtask

    // Legal encodings keyed by {opcode, funct3, funct7}; fields that do not matter are zeroed.
    task automatic add(input logic [6:0] opc, input logic [2:0] f3, input logic [6:0] f7, input logic [5:0] code);
        enc_tbl[{opc, f3, f7}] = code;
    endtask

    task automatic build_table();
        logic [5:0] base[8] = '{ALU_ADD, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR, ALU_SRL, ALU_OR, ALU_AND};
        logic [5:0] mext[8] = '{ALU_MUL, ALU_MULH, ALU_MULHSU, ALU_MULHU, ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU};
        for (int i = 0; i < 8; i++) begin
            add(7'h33, 3'(i), 7'h00, base[i]);
            add(7'h33, 3'(i), 7'h01, mext[i]);
            if (i != 1 && i != 5) add(7'h13, 3'(i), 7'h00, base[i]);
        end
        add(7'h33, 3'd0, 7'h20, ALU_SUB);
        add(7'h33, 3'd5, 7'h20, ALU_SRA);
        add(7'h13, 3'd1, 7'h00, ALU_SLL);
        add(7'h13, 3'd5, 7'h00, ALU_SRL);
        add(7'h13, 3'd5, 7'h20, ALU_SRA);
        add(7'h03, 3'd0, 7'h00, ALU_LB);  add(7'h03, 3'd1, 7'h00, ALU_LH);
        add(7'h03, 3'd2, 7'h00, ALU_LW);  add(7'h03, 3'd4, 7'h00, ALU_LBU);
        add(7'h03, 3'd5, 7'h00, ALU_LHU);
        add(7'h23, 3'd0, 7'h00, ALU_SB);  add(7'h23, 3'd1, 7'h00, ALU_SH);
        add(7'h23, 3'd2, 7'h00, ALU_SW);
        add(7'h63, 3'd0, 7'h00, ALU_BEQ); add(7'h63, 3'd1, 7'h00, ALU_BNE);
        add(7'h63, 3'd4, 7'h00, ALU_BLT); add(7'h63, 3'd5, 7'h00, ALU_BGE);
        add(7'h63, 3'd6, 7'h00, ALU_BLTU); add(7'h63, 3'd7, 7'h00, ALU_BGEU);
        add(7'h67, 3'd0, 7'h00, ALU_JALR);
        add(7'h37, 3'd0, 7'h00, ALU_LUI);
        add(7'h17, 3'd0, 7'h00, ALU_ADD);
        add(7'h6f, 3'd0, 7'h00, ALU_JAL);
    endtask

    function automatic exp_t model(input logic [31:0] inst, input logic [31:0] pc,
                                   input logic [31:0] r1, input logic [31:0] r2);
        exp_t        e;
        logic [6:0]  opc = inst[6:0];
        logic [2:0]  f3  = inst[14:12];
        logic [31:0] sgn = 32'($signed(inst) >>> 31);
        logic [31:0] iimm, simm, bimm, jimm, uimm;
        bit          shift = (opc == 7'h13) && (f3 == 3'd1 || f3 == 3'd5);
        logic [16:0] key;
        iimm = 32'($signed(inst) >>> 20);
        simm = (iimm & 32'hFFFF_FFE0) | 32'(inst[11:7]);
        bimm = (sgn << 12) | (32'(inst[7]) << 11) | (32'(inst[30:25]) << 5) | (32'(inst[11:8]) << 1);
        jimm = (sgn << 20) | (32'(inst[19:12]) << 12) | (32'(inst[20]) << 11) | (32'(inst[30:21]) << 1);
        uimm = inst & 32'hFFFF_F000;
        key  = {opc, (opc == 7'h37 || opc == 7'h17 || opc == 7'h6f) ? 3'd0 : f3,
                (opc == 7'h33 || shift) ? inst[31:25] : 7'd0};

        e.pc = pc; e.op1 = r1; e.op2 = r2; e.br = pc + 32'd4; e.rd = inst[11:7];
        e.reg_we = (inst[11:7] != 5'd0); e.mem_we = 1'b0; e.ill = 1'b0;
        e.op1_c = 1; e.op2_c = 1; e.br_c = 1; e.rd_c = 1;
        if (!enc_tbl.exists(key)) begin
            e.alu = ALU_ADD; e.reg_we = 0; e.mem_we = 0; e.ill = 1;
            e.op1_c = 0; e.op2_c = 0; e.br_c = 0; e.rd_c = 0;
            return e;
        end
        e.alu = enc_tbl[key];
        case (opc)
            7'h13: e.op2 = shift ? 32'(inst[24:20]) : iimm;
            7'h03: e.op2 = iimm;
            7'h23: begin e.op2 = simm; e.mem_we = 1; e.reg_we = 0; e.rd_c = 0; end
            7'h37: begin e.op1_c = 0; e.op2 = uimm; end
            7'h17: begin e.op1 = pc; e.op2 = uimm; end
            7'h6f: begin e.op1_c = 0; e.op2 = pc; e.br = pc + jimm; end
            7'h67: begin e.op1_c = 0; e.op2 = pc; e.br = (r1 + iimm) & ~32'd1; end
            7'h63: begin e.br = pc + bimm; e.reg_we = 0; e.rd_c = 0; end
            default: ;
        endcase
        return e;
    endfunction

    task automatic compare(input exp_t e);
        check("alucode", 32'(alucode), 32'(e.alu));
        if (e.op1_c) check("op1", op1, e.op1);
        if (e.op2_c) check("op2", op2, e.op2);
        if (e.br_c)  check("br_target", br_target, e.br);
        if (e.rd_c)  check("rd", 32'(rd), 32'(e.rd));
        check("out_pc", out_pc, e.pc);
        check("reg_we", 32'(reg_we), 32'(e.reg_we));
        check("mem_we", 32'(mem_we), 32'(e.mem_we));
        check("illegal", 32'(illegal), 32'(e.ill));
    endtask

    // Monitor: the front of the queue is what the DUT must be presenting right now.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1) begin
                check("out_valid", 32'(out_valid), 32'(sb.size() != 0));
                check("in_ready", 32'(in_ready), 32'((sb.size() == 0) || out_ready));
                if (out_valid === 1'b1 && sb.size() != 0) compare(sb[0]);
                else if (out_valid === 1'b0) check("empty_out_pc", out_pc, RST_PC);
                if (sb.size() != 0 && (flush || out_ready)) void'(sb.pop_front());
            end
        end
    end

    // One clock of stimulus; entered and left at posedge+1.
    task automatic cycle(input logic v, input logic [31:0] inst, input logic [31:0] pc,
                         input logic [31:0] r1, input logic [31:0] r2,
                         input logic fl, input logic rdy, output bit acc);
        in_valid = v; in_inst = inst; in_pc = pc; rs1_data = r1; rs2_data = r2;
        flush = fl; out_ready = rdy;
        @(negedge clk);
        check("rs1_addr", 32'(rs1_addr), 32'(inst[19:15]));
        check("rs2_addr", 32'(rs2_addr), 32'(inst[24:20]));
        acc = v && in_ready && !fl;
        @(posedge clk);
        #1;
        if (acc) sb.push_back(model(inst, pc, r1, r2));
    endtask

    task automatic issue(input logic [31:0] inst, input logic [31:0] pc,
                         input logic [31:0] r1, input logic [31:0] r2);
        bit acc = 0;
        int n = 0;
        while (!acc && n < 20) begin
            cycle(1'b1, inst, pc, r1, r2, 1'b0, 1'b1, acc);
            n++;
        end
        check("issue_accept", 32'(acc), 32'd1);
    endtask

    function automatic logic [31:0] gen_inst();
        logic [31:0] w = $urandom;
        if ($urandom_range(0, 9) < 8) begin
            case ($urandom_range(0, 8))
                0: w[6:0] = 7'h33;  1: w[6:0] = 7'h13;  2: w[6:0] = 7'h03;
                3: w[6:0] = 7'h23;  4: w[6:0] = 7'h37;  5: w[6:0] = 7'h17;
                6: w[6:0] = 7'h6f;  7: w[6:0] = 7'h67;  default: w[6:0] = 7'h63;
            endcase
            case ($urandom_range(0, 3))
                0: w[31:25] = 7'h00;
                1: w[31:25] = 7'h20;
                2: w[31:25] = 7'h01;
                default: ;
            endcase
        end
        return w;
    endfunction

    initial begin
        bit          acc;
        logic [31:0] r1;
        build_table();
        rst_n = 1'b0; in_valid = 0; in_inst = '0; in_pc = '0; rs1_data = '0; rs2_data = '0;
        flush = 0; out_ready = 0;
        #12;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_pc", out_pc, RST_PC);
        check("rst_alucode", 32'(alucode), 32'(ALU_ADD));
        check("rst_reg_we", 32'(reg_we), 32'd0);
        @(posedge clk); #1 rst_n = 1'b1;

        issue(32'hFFB1_0093, 32'h40, 32'd10, 32'd3);
        check("addi_alucode", 32'(alucode), 32'(ALU_ADD));
        check("addi_op1", op1, 32'd10);
        check("addi_op2", op2, 32'hFFFF_FFFB);
        check("addi_rd", 32'(rd), 32'd1);
        check("addi_reg_we", 32'(reg_we), 32'd1);

        issue(32'h1234_52B7, 32'h44, 32'd0, 32'd0);
        check("lui_alucode", 32'(alucode), 32'(ALU_LUI));
        check("lui_op2", op2, 32'h1234_5000);
        check("lui_rd", 32'(rd), 32'd5);

        issue(32'h0020_8463, 32'h100, 32'd7, 32'd7);
        check("beq_alucode", 32'(alucode), 32'(ALU_BEQ));
        check("beq_target", br_target, 32'h108);
        check("beq_reg_we", 32'(reg_we), 32'd0);

        issue(32'h0041_80E7, 32'h200, 32'h1001, 32'd0);
        check("jalr_alucode", 32'(alucode), 32'(ALU_JALR));
        check("jalr_op2", op2, 32'h200);
        check("jalr_target", br_target, 32'h1004);

        // Stall three cycles with a second instruction waiting, then flush both.
        cycle(1'b0, '0, '0, '0, '0, 1'b0, 1'b1, acc);
        cycle(1'b1, 32'h0031_00B3, 32'h300, 32'd5, 32'd6, 1'b0, 1'b0, acc);
        check("stall_first_accept", 32'(acc), 32'd1);
        for (int i = 0; i < 3; i++) begin
            cycle(1'b1, 32'h0050_0113, 32'h304, 32'd1, 32'd2, 1'b0, 1'b0, acc);
            check("stall_accept", 32'(acc), 32'd0);
            check("stall_in_ready", 32'(in_ready), 32'd0);
        end
        cycle(1'b1, 32'h0050_0113, 32'h304, 32'd1, 32'd2, 1'b1, 1'b0, acc);
        check("flush_accept", 32'(acc), 32'd0);
        check("flush_out_valid", 32'(out_valid), 32'd0);

        // Asynchronous reset in the middle of a stall.
        cycle(1'b1, 32'h0041_2183, 32'h400, 32'h80, 32'd0, 1'b0, 1'b0, acc);
        cycle(1'b0, '0, '0, '0, '0, 1'b0, 1'b0, acc);
        #3 rst_n = 1'b0;
        #1;
        sb.delete();
        check("async_rst_valid", 32'(out_valid), 32'd0);
        check("async_rst_pc", out_pc, RST_PC);
        check("async_rst_alucode", 32'(alucode), 32'(ALU_ADD));
        check("async_rst_op1", op1, 32'd0);
        check("async_rst_op2", op2, 32'd0);
        check("async_rst_br", br_target, 32'd0);
        check("async_rst_rd", 32'(rd), 32'd0);
        check("async_rst_we", 32'({reg_we, mem_we, illegal}), 32'd0);
        @(posedge clk); #1 rst_n = 1'b1;

        issue(32'hFFFF_FFFF, 32'h500, 32'd1, 32'd2);
        check("ill_flag", 32'(illegal), 32'd1);
        check("ill_reg_we", 32'(reg_we), 32'd0);
        check("ill_mem_we", 32'(mem_we), 32'd0);
        check("ill_alucode", 32'(alucode), 32'(ALU_ADD));

        for (int i = 0; i < 3000; i++) begin
            r1 = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFF : $urandom;
            cycle($urandom_range(0, 3) != 0, gen_inst(), $urandom & 32'hFFFF_FFFC, r1, $urandom,
                  $urandom_range(0, 15) == 0, $urandom_range(0, 3) != 0, acc);
        end

        cycle(1'b0, '0, '0, '0, '0, 1'b0, 1'b1, acc);
        cycle(1'b0, '0, '0, '0, '0, 1'b0, 1'b1, acc);
        check("drain_empty", 32'(sb.size()), 32'd0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
